d_uncached_wbuf: RTL and testbench
==================================

Name: d_uncached_wbuf

Overview:
- Posted write buffer between d_cache (uncached store path) and the AXI arbiter's d_aw/d_w/d_b channels.
- Accepts single-beat uncached stores in one cycle so the memory stage does not stall for the AXI B round-trip.
- Drains entries in order as single-beat AXI writes.
- Exposes empty/hit status so d_cache holds uncached loads until conflicting writes have completed.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  store request from d_cache
- req_ready  out  1  buffer can accept this cycle
- req_addr  in  32  physical byte address
- req_wdata  in  32  store data, lane-aligned
- req_wstrb  in  4  byte enables
- req_size  in  3  AXI size: 0 = byte, 1 = half, 2 = word
- chk_addr  in  32  physical address of a pending uncached load
- hit  out  1  some valid entry has the same word address (bits 31:2) as chk_addr
- empty  out  1  no entries, including in-flight
- count  out  PTR_W+1  number of valid entries
- d_awaddr  out  32  AW address
- d_awlen  out  8  always 0
- d_awsize  out  3  entry size
- d_awvalid  out  1  AW valid
- d_awready  in  1  AW ready
- d_wdata  out  32  W data
- d_wstrb  out  4  W strobes
- d_wlast  out  1  always 1 while d_wvalid
- d_wvalid  out  1  W valid
- d_wready  in  1  W ready
- d_bvalid  in  1  B valid
- d_bready  out  1  B ready

Behaviour:
- Reset: all control outputs are driven to their reset values.
  - head = tail = count = 0, FSM = IDLE.
  - d_awvalid = d_wvalid = d_bready = 0, empty = 1, hit = 0, req_ready = 1.
  - Data outputs are 0.
- Storage: circular FIFO of {addr, wdata, wstrb, size}. Pointers wrap modulo DEPTH.
- Push: when req_valid & req_ready, write to tail, tail+1, count+1.
  - req_ready = (count != DEPTH), registered-state only.
  - A push is never accepted while full, even if a pop completes in the same cycle.
- Entries stay counted until the B response. The in-flight entry is included in count, empty and hit.
- FSM:
  - IDLE: if count != 0, load the head entry to output registers, set aw_done = w_done = 0, go to SEND. First d_awvalid is 1 cycle after the push that made the buffer non-empty.
  - SEND: d_awvalid = !aw_done and d_wvalid = !w_done, asserted together.
    - AW handshake sets aw_done; W handshake sets w_done. Either order, or the same cycle.
    - When both are done (including same-cycle completion), go to RESP.
    - Valids never drop before their handshake; addr/data are stable while valid.
  - RESP: d_bready = 1. On d_bvalid, pop head (head+1, count-1) and go to IDLE.
    - bresp is ignored.
    - The next entry is sent from IDLE, giving 1 idle cycle between bursts.
- Simultaneous push and pop: count unchanged, both pointers advance.
- hit: combinational OR over valid entries of (entry.addr[31:2] == chk_addr[31:2]).
- empty = (count == 0).
- Reset mid-transaction drops all entries immediately. The interconnect is reset by the same rst.

Optional Feature:
- Macro: WBUF_MERGE_EN.
- With the macro: a push whose addr[31:2] matches the tail-most valid entry merges into it instead of allocating, provided that entry is not the in-flight head.
  - Merge: byte-wise data overwrite where req_wstrb is set, OR the strobes, set size = 2.
  - count is unchanged. req_ready is still 1 when full if the merge condition holds.
- Without the macro: every accepted push allocates a new entry; no comparison logic.

Test Plan:
- Single store: push addr 0x1FAF_F010, data 0xDEAD_BEEF, strb 0xF, size 2, with awready = wready = 1 and bvalid 2 cycles later -> awvalid in cycle +1 with awaddr 0x1FAF_F010, awlen 0, wlast 1; count back to 0 and empty = 1 the cycle after bvalid.
- Fill to full: push 4 stores while awready = 0 -> count = 4, req_ready = 0, 5th request held. Release awready/wready/bvalid -> 4 writes in push order; req_ready returns to 1 after the first B.
- Split handshake: wready = 1 on cycle 1, awready = 1 on cycle 4 -> wvalid drops after cycle 1, awvalid holds until cycle 4, one B accepted, no duplicate beat.
- Hazard: pending store to 0x1FD0_0004 in RESP, chk_addr 0x1FD0_0006 -> hit = 1; after bvalid -> hit = 0.
- Reset mid-SEND with count = 3 -> next cycle count = 0, awvalid = 0, empty = 1.
- WBUF_MERGE_EN: with head in flight, push byte 0xAA (strb 0x1) then byte 0xBB (strb 0x2) to 0x1FD0_0100 -> single queued entry, strb 0x3, data[15:0] = 0xBBAA, size 2.

Source files
------------

// File: rtl/d_uncached_wbuf.sv
// Posted write buffer for uncached stores: in-order single-beat AXI drain, hit/empty for load hazards.
// Define WBUF_MERGE_EN to coalesce same-word stores into the tail-most queued (not in-flight) entry.
module d_uncached_wbuf #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  input  logic [2:0]        req_size,
  input  logic [31:0]       chk_addr,
  output logic              hit,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic [31:0]       d_awaddr,
  output logic [7:0]        d_awlen,
  output logic [2:0]        d_awsize,
  output logic              d_awvalid,
  input  logic              d_awready,
  output logic [31:0]       d_wdata,
  output logic [3:0]        d_wstrb,
  output logic              d_wlast,
  output logic              d_wvalid,
  input  logic              d_wready,
  input  logic              d_bvalid,
  output logic              d_bready
);
  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ZERO = '0;

  state_t           state;
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       strb_q [DEPTH];
  logic [2:0]       size_q [DEPTH];
  logic [PTR_W-1:0] head, tail, last;
  logic [PTR_W:0]   count_q;
  logic [DEPTH-1:0] vld, hit_v;
  logic             push, alloc, pop, merge;

  assign last = tail - PTR_W'(1);

  // Entry i is live when its distance from head is below count; the in-flight head counts too.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] off;
    assign off      = PTR_W'(i) - head;
    assign vld[i]   = {1'b0, off} < count_q;
    assign hit_v[i] = vld[i] && (addr_q[i][31:2] == chk_addr[31:2]);
  end

`ifdef WBUF_MERGE_EN
  // With two or more entries the tail-most one can never be the head being sent.
  assign merge     = (count_q > (PTR_W+1)'(1)) && (addr_q[last][31:2] == req_addr[31:2]);
  assign req_ready = (count_q != FULL) || merge;
`else
  assign merge     = 1'b0;
  assign req_ready = (count_q != FULL);
`endif

  assign push    = req_valid && req_ready;
  assign alloc   = push && !merge;
  assign pop     = (state == RESP) && d_bvalid;
  assign hit     = |hit_v;
  assign empty   = (count_q == ZERO);
  assign count   = count_q;
  assign d_awlen = 8'd0;
  assign d_wlast = d_wvalid;

  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail] <= req_addr;
      data_q[tail] <= req_wdata;
      strb_q[tail] <= req_wstrb;
      size_q[tail] <= req_size;
    end
`ifdef WBUF_MERGE_EN
    else if (push) begin
      for (int b = 0; b < 4; b++)
        if (req_wstrb[b]) data_q[last][8*b +: 8] <= req_wdata[8*b +: 8];
      strb_q[last] <= strb_q[last] | req_wstrb;
      size_q[last] <= 3'd2;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      state     <= IDLE;
      d_awvalid <= 1'b0;
      d_wvalid  <= 1'b0;
      d_bready  <= 1'b0;
      d_awaddr  <= '0;
      d_awsize  <= '0;
      d_wdata   <= '0;
      d_wstrb   <= '0;
    end else begin
      if (alloc) tail <= tail + PTR_W'(1);
      if (pop)   head <= head + PTR_W'(1);
      if (alloc && !pop)      count_q <= count_q + (PTR_W+1)'(1);
      else if (pop && !alloc) count_q <= count_q - (PTR_W+1)'(1);
      case (state)
        IDLE: if (count_q != ZERO) begin
          d_awaddr  <= addr_q[head];
          d_awsize  <= size_q[head];
          d_wdata   <= data_q[head];
          d_wstrb   <= strb_q[head];
          d_awvalid <= 1'b1;
          d_wvalid  <= 1'b1;
          state     <= SEND;
        end
        // A dropped valid doubles as the channel's done flag.
        SEND: begin
          if (d_awready) d_awvalid <= 1'b0;
          if (d_wready)  d_wvalid  <= 1'b0;
          if ((!d_awvalid || d_awready) && (!d_wvalid || d_wready)) begin
            d_bready <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: if (d_bvalid) begin
          d_bready <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_d_uncached_wbuf.sv
// Directed bench for d_uncached_wbuf: single store, fill/drain, split handshake, hazard, reset, merge.
module tb_d_uncached_wbuf;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0, chk_addr = '0;
  logic [3:0]  req_wstrb = '0;
  logic [2:0]  req_size = '0;
  logic        hit, empty;
  logic [2:0]  count;
  logic [31:0] d_awaddr, d_wdata;
  logic [7:0]  d_awlen;
  logic [2:0]  d_awsize;
  logic        d_awvalid, d_awready = 1'b0;
  logic [3:0]  d_wstrb;
  logic        d_wlast, d_wvalid, d_wready = 1'b0;
  logic        d_bvalid = 1'b0, d_bready;
  int total = 0, bad = 0;

  d_uncached_wbuf #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_size(req_size),
    .chk_addr(chk_addr), .hit(hit), .empty(empty), .count(count),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid),
    .d_awready(d_awready), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
    .d_wvalid(d_wvalid), .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] z);
    req_addr = a; req_wdata = d; req_wstrb = s; req_size = z; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Expects awready/wready high; checks the beat, then answers with one B.
  task automatic drain(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                       input logic [3:0] es, input logic [2:0] ez);
    int n = 0;
    while (!d_awvalid && n < 20) begin tick(); n++; end
    chk({tag, "_awvalid"}, d_awvalid, 1);
    chk({tag, "_awaddr"}, d_awaddr, ea);
    chk({tag, "_wdata"}, d_wdata, ed);
    chk({tag, "_wstrb"}, d_wstrb, es);
    chk({tag, "_awsize"}, d_awsize, ez);
    n = 0;
    while (!d_bready && n < 20) begin tick(); n++; end
    chk({tag, "_bready"}, d_bready, 1);
    d_bvalid = 1'b1;
    tick();
    d_bvalid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", req_ready, 1);
    chk("rst_awvalid", d_awvalid, 0);
    chk("rst_wvalid", d_wvalid, 0);
    chk("rst_bready", d_bready, 0);
    chk("rst_hit", hit, 0);
    chk("rst_awaddr", d_awaddr, 0);

    // single store
    d_awready = 1'b1; d_wready = 1'b1;
    push(32'h1FAF_F010, 32'hDEAD_BEEF, 4'hF, 3'd2);
    chk("s1_count", count, 1);
    chk("s1_empty", empty, 0);
    chk("s1_aw_early", d_awvalid, 0);
    tick();
    chk("s1_awvalid", d_awvalid, 1);
    chk("s1_awaddr", d_awaddr, 32'h1FAF_F010);
    chk("s1_awlen", d_awlen, 0);
    chk("s1_awsize", d_awsize, 2);
    chk("s1_wvalid", d_wvalid, 1);
    chk("s1_wlast", d_wlast, 1);
    chk("s1_wdata", d_wdata, 32'hDEAD_BEEF);
    tick();
    chk("s1_aw_done", d_awvalid, 0);
    chk("s1_w_done", d_wvalid, 0);
    chk("s1_bready", d_bready, 1);
    tick();
    chk("s1_wait_count", count, 1);
    d_bvalid = 1'b1;
    tick();
    d_bvalid = 1'b0;
    chk("s1_count_end", count, 0);
    chk("s1_empty_end", empty, 1);
    chk("s1_bready_end", d_bready, 0);

    // fill to full, hold a fifth request, drain in order
    d_awready = 1'b0; d_wready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(32'h1000_0000 + 32'(4*i), 32'h1111_0000 + 32'(i), 4'hF, 3'd2);
    chk("full_count", count, 4);
    chk("full_ready", req_ready, 0);
    req_addr = 32'h1000_0010; req_wdata = 32'h1111_0004; req_wstrb = 4'hF; req_size = 3'd2;
    req_valid = 1'b1;
    tick();
    chk("full_held_count", count, 4);
    chk("full_held_ready", req_ready, 0);
    d_awready = 1'b1; d_wready = 1'b1;
    drain("f0", 32'h1000_0000, 32'h1111_0000, 4'hF, 3'd2);
    chk("f0_count", count, 3);
    chk("f0_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("f5_count", count, 4);
    for (int i = 1; i < 5; i++)
      drain($sformatf("f%0d", i), 32'h1000_0000 + 32'(4*i), 32'h1111_0000 + 32'(i), 4'hF, 3'd2);
    chk("fill_empty", empty, 1);

    // W accepted first, AW three cycles later
    d_awready = 1'b0; d_wready = 1'b1;
    push(32'h2000_0000, 32'hCAFE_F00D, 4'hF, 3'd2);
    tick();
    chk("sp_aw1", d_awvalid, 1);
    chk("sp_w1", d_wvalid, 1);
    tick();
    chk("sp_aw2", d_awvalid, 1);
    chk("sp_w2", d_wvalid, 0);
    tick(); tick();
    chk("sp_aw4", d_awvalid, 1);
    chk("sp_w4", d_wvalid, 0);
    chk("sp_b4", d_bready, 0);
    chk("sp_addr4", d_awaddr, 32'h2000_0000);
    d_awready = 1'b1;
    tick();
    chk("sp_aw5", d_awvalid, 0);
    chk("sp_w5", d_wvalid, 0);
    chk("sp_b5", d_bready, 1);
    d_bvalid = 1'b1;
    tick();
    d_bvalid = 1'b0;
    chk("sp_count", count, 0);
    tick();
    chk("sp_no_dup_aw", d_awvalid, 0);
    chk("sp_no_dup_w", d_wvalid, 0);

    // load hazard against an in-flight store
    chk_addr = 32'h1FD0_0006;
    push(32'h1FD0_0004, 32'h0000_1234, 4'hF, 3'd2);
    chk("hz_hit_q", hit, 1);
    tick(); tick();
    chk("hz_bready", d_bready, 1);
    chk("hz_hit_resp", hit, 1);
    chk_addr = 32'h1FD0_0008;
    #1;
    chk("hz_other_word", hit, 0);
    chk_addr = 32'h1FD0_0006;
    d_bvalid = 1'b1;
    tick();
    d_bvalid = 1'b0;
    chk("hz_hit_done", hit, 0);

    // reset mid-SEND with three entries
    d_awready = 1'b0; d_wready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(32'h3000_0000 + 32'(4*i), 32'h3333_0000 + 32'(i), 4'hF, 3'd2);
    chk("rs_count", count, 3);
    chk("rs_awvalid", d_awvalid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_count0", count, 0);
    chk("rs_awvalid0", d_awvalid, 0);
    chk("rs_wvalid0", d_wvalid, 0);
    chk("rs_empty", empty, 1);
    chk("rs_ready", req_ready, 1);

    // two byte stores to one word behind an in-flight head
    push(32'h1FD0_0200, 32'h1234_5678, 4'hF, 3'd2);
    push(32'h1FD0_0100, 32'h0000_00AA, 4'h1, 3'd0);
    push(32'h1FD0_0100, 32'h0000_BB00, 4'h2, 3'd0);
`ifdef WBUF_MERGE_EN
    chk("mg_count", count, 2);
    d_awready = 1'b1; d_wready = 1'b1;
    drain("mg_head", 32'h1FD0_0200, 32'h1234_5678, 4'hF, 3'd2);
    drain("mg_merged", 32'h1FD0_0100, 32'h0000_BBAA, 4'h3, 3'd2);
`else
    chk("nm_count", count, 3);
    d_awready = 1'b1; d_wready = 1'b1;
    drain("nm_head", 32'h1FD0_0200, 32'h1234_5678, 4'hF, 3'd2);
    drain("nm_b0", 32'h1FD0_0100, 32'h0000_00AA, 4'h1, 3'd0);
    drain("nm_b1", 32'h1FD0_0100, 32'h0000_BB00, 4'h2, 3'd0);
`endif
    chk("end_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
